// File: rtl/sd_block_streamer.sv
// sd_block_streamer: streams sequential SD blocks through a ping-pong buffer to a valid/ready byte port
// Ports:
//   MasterCLK, Reset               clock, async active-high reset
//   Start, Stop, StartBlock        control pulses and first block address
//   SD_ReadReq/Addr/Ack            block-read request handshake to SD_SPI
//   SD_ByteValid/Data, SD_BlockDone, SD_Error   receive side from SD_SPI
//   Out_Valid/Data/Ready           output byte stream
//   Busy, ErrorFlag, Underrun      status
module sd_block_streamer #(
    parameter int BLOCK_BYTES = 512,
    parameter int ADDR_WIDTH  = 32,
    parameter int START_WIDTH = 16
) (
    input  logic                   MasterCLK,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic                   Stop,
    input  logic [START_WIDTH-1:0] StartBlock,
    output logic                   SD_ReadReq,
    output logic [ADDR_WIDTH-1:0]  SD_ReadAddr,
    input  logic                   SD_ReadAck,
    input  logic                   SD_ByteValid,
    input  logic [7:0]             SD_ByteData,
    input  logic                   SD_BlockDone,
    input  logic                   SD_Error,
    output logic                   Out_Valid,
    output logic [7:0]             Out_Data,
    input  logic                   Out_Ready,
    output logic                   Busy,
    output logic                   ErrorFlag,
    output logic                   Underrun
);
    localparam int PW = $clog2(BLOCK_BYTES);

    typedef enum logic [2:0] {IDLE, REQ, RECV, WAITBANK, ERR} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [PW:0]             wptr_q, wptr_d;
    logic [PW-1:0]           fptr_q, fptr_d, dcnt_q, dcnt_d;
    logic [1:0]              full_q, full_d;
    logic [7:0]              od_q, od_d;
    logic [7:0]              rdata_q;
    logic [7:0]              mem [2*BLOCK_BYTES];
    logic wb_q, wb_d, fb_q, fb_d, rb_q, rb_d;
    logic stop_q, stop_d, err_q, err_d, req_q, req_d, busy_q, busy_d, stream_q, stream_d;
    logic rv_q, rv_d, ov_q, ov_d;
    logic restart, wr_en, rd_en, mv, acc, last, set_full;

    // Read side is a two-stage pipeline: RAM read register (rv) feeding the
    // output register (ov). Fetch bank/pointer (fb/fptr) run ahead of the
    // drain bank/count (rb/dcnt) so bank switches cost no bubble; a bank is
    // only released once its last byte has actually been accepted.
    always_comb begin
        restart  = Start & (state_q == IDLE | state_q == ERR);
        wr_en    = state_q == RECV & SD_ByteValid & ~wptr_q[PW];
        acc      = ov_q & Out_Ready;
        last     = acc & (&dcnt_q);
        mv       = rv_q & (~ov_q | Out_Ready);
        rd_en    = full_q[fb_q] & (~rv_q | mv);
        rv_d     = rd_en | (rv_q & ~mv);
        ov_d     = mv | (ov_q & ~Out_Ready);
        od_d     = mv ? rdata_q : od_q;
        fptr_d   = fptr_q + PW'(rd_en);
        fb_d     = fb_q ^ (rd_en & (&fptr_q));
        dcnt_d   = dcnt_q + PW'(acc);
        rb_d     = rb_q ^ last;
        state_d  = state_q;
        addr_d   = addr_q;
        wptr_d   = wptr_q + (PW+1)'(wr_en);
        wb_d     = wb_q;
        err_d    = err_q;
        set_full = 1'b0;
        stop_d   = stop_q | (Stop & state_q != IDLE);
        case (state_q)
            IDLE, ERR: if (restart) begin
                state_d = REQ;
                addr_d  = ADDR_WIDTH'(StartBlock);
                err_d   = 1'b0;
                stop_d  = 1'b0;
                wb_d    = 1'b0;
            end
            REQ: begin
                if (SD_Error) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else if (SD_ReadAck) begin
                    state_d = RECV;
                    wptr_d  = '0;
                end else if (stop_d) begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                // A block that ends short is treated exactly like an abort.
                if (SD_Error | (SD_BlockDone & ~wptr_q[PW])) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else if (SD_BlockDone) begin
                    set_full = 1'b1;
                    wb_d     = ~wb_q;
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    state_d  = stop_d ? IDLE : full_q[~wb_q] ? WAITBANK : REQ;
                end
            end
            WAITBANK: state_d = stop_d ? IDLE : full_q[wb_q] ? WAITBANK : REQ;
            default:  state_d = IDLE;
        endcase
        if (state_d == IDLE) stop_d = 1'b0;
        full_d = full_q;
        if (last) full_d[rb_q] = 1'b0;
        if (set_full) full_d[wb_q] = 1'b1;
        if (restart) begin
            full_d = '0;
            fptr_d = '0;
            dcnt_d = '0;
            fb_d   = 1'b0;
            rb_d   = 1'b0;
            rv_d   = 1'b0;
            ov_d   = 1'b0;
        end
        req_d    = state_d == REQ;
        busy_d   = state_d != IDLE;
        stream_d = state_d == REQ | state_d == RECV | state_d == WAITBANK;
    end

    always_ff @(posedge MasterCLK) begin
        if (wr_en) mem[{wb_q, wptr_q[PW-1:0]}] <= SD_ByteData;
        if (rd_en) rdata_q <= mem[{fb_q, fptr_q}];
    end

    always_ff @(posedge MasterCLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wptr_q   <= '0;
            fptr_q   <= '0;
            dcnt_q   <= '0;
            full_q   <= '0;
            od_q     <= '0;
            wb_q     <= 1'b0;
            fb_q     <= 1'b0;
            rb_q     <= 1'b0;
            stop_q   <= 1'b0;
            err_q    <= 1'b0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            stream_q <= 1'b0;
            rv_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wptr_q   <= wptr_d;
            fptr_q   <= fptr_d;
            dcnt_q   <= dcnt_d;
            full_q   <= full_d;
            od_q     <= od_d;
            wb_q     <= wb_d;
            fb_q     <= fb_d;
            rb_q     <= rb_d;
            stop_q   <= stop_d;
            err_q    <= err_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            stream_q <= stream_d;
            rv_q     <= rv_d;
            ov_q     <= ov_d;
        end
    end

    assign SD_ReadReq  = req_q;
    assign SD_ReadAddr = addr_q;
    assign Busy        = busy_q;
    assign ErrorFlag   = err_q;
    assign Out_Valid   = ov_q;
    assign Out_Data    = od_q;
    assign Underrun    = stream_q & Out_Ready & ~ov_q;
endmodule

// File: tb/tb_sd_block_streamer.sv
// tb_sd_block_streamer: randomized SD source and consumer against a queue-based stream model
module tb_sd_block_streamer;
    localparam int AW = 16;
    localparam int SW = 16;
    localparam int BB = 512;

    logic          MasterCLK = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic          Stop = 1'b0;
    logic [SW-1:0] StartBlock = '0;
    logic          SD_ReadReq;
    logic [AW-1:0] SD_ReadAddr;
    logic          SD_ReadAck = 1'b0;
    logic          SD_ByteValid = 1'b0;
    logic [7:0]    SD_ByteData = '0;
    logic          SD_BlockDone = 1'b0;
    logic          SD_Error = 1'b0;
    logic          Out_Valid;
    logic [7:0]    Out_Data;
    logic          Out_Ready = 1'b0;
    logic          Busy;
    logic          ErrorFlag;
    logic          Underrun;

    always #5 MasterCLK = ~MasterCLK;

    sd_block_streamer #(.BLOCK_BYTES(BB), .ADDR_WIDTH(AW), .START_WIDTH(SW)) dut (
        .MasterCLK(MasterCLK), .Reset(Reset), .Start(Start), .Stop(Stop), .StartBlock(StartBlock),
        .SD_ReadReq(SD_ReadReq), .SD_ReadAddr(SD_ReadAddr), .SD_ReadAck(SD_ReadAck),
        .SD_ByteValid(SD_ByteValid), .SD_ByteData(SD_ByteData), .SD_BlockDone(SD_BlockDone),
        .SD_Error(SD_Error), .Out_Valid(Out_Valid), .Out_Data(Out_Data), .Out_Ready(Out_Ready),
        .Busy(Busy), .ErrorFlag(ErrorFlag), .Underrun(Underrun)
    );

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] blk[BB];
    logic [AW-1:0] exp_addr = '0;
    int         rdy_mode = 0;
    int         acc_cnt = 0;
    int         req_cnt = 0;
    int         bubbles = 0;
    int         track_end = 0;
    int         acc0 = 0;
    int         r0 = 0;
    bit         track = 1'b0;
    bit         prev_stall = 1'b0;
    bit         prev_req = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consumer-side scoreboard: every accepted byte must be the next byte of a
    // completed block, and a stalled byte must be held unchanged.
    always @(negedge MasterCLK) begin
        if (Reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", Out_Valid, 1);
                chk("hold_data", Out_Data, prev_data);
            end
            if (track && !Out_Valid) bubbles++;
            if (Out_Valid && Out_Ready) begin
                n_vec++;
                assert (exp_q.size() != 0) else begin
                    n_bad++;
                    $error("FAIL extra_byte: observed %0h expected no byte", Out_Data);
                end
                if (exp_q.size() != 0) chk("out_byte", Out_Data, exp_q.pop_front());
                acc_cnt++;
                if (track && acc_cnt >= track_end) track = 1'b0;
            end
            prev_stall = Out_Valid && !Out_Ready;
            prev_data  = Out_Data;
            if (SD_ReadReq && !prev_req) req_cnt++;
            prev_req = SD_ReadReq;
        end
    end

    task automatic upd_rdy();
        Out_Ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    endtask

    task automatic set_rdy(input int m);
        rdy_mode = m;
        upd_rdy();
    endtask

    task automatic tick();
        @(posedge MasterCLK);
        #1;
        upd_rdy();
    endtask

    task automatic wait_req();
        int n = 0;
        while (!SD_ReadReq && n < 3000) begin
            tick();
            n++;
        end
        chk("req_seen", SD_ReadReq, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || Out_Valid) && n < 5000) begin
            tick();
            n++;
        end
        chk("drained", exp_q.size(), 0);
    endtask

    task automatic send_bytes(input int n, input int stop_at);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            b = 8'($urandom);
            blk[i] = b;
            SD_ByteValid = 1'b1;
            SD_ByteData = b;
            Stop = (i == stop_at);
            tick();
            SD_ByteValid = 1'b0;
            Stop = 1'b0;
        end
    endtask

    task automatic send_block(input int n, input int err_at, input int stop_at, input bit lat);
        wait_req();
        chk("req_addr", SD_ReadAddr, exp_addr);
        SD_ReadAck = 1'b1;
        tick();
        SD_ReadAck = 1'b0;
        if (err_at >= 0) begin
            send_bytes(err_at, -1);
            SD_Error = 1'b1;
            tick();
            SD_Error = 1'b0;
            return;
        end
        send_bytes(n, stop_at);
        SD_BlockDone = 1'b1;
        tick();
        SD_BlockDone = 1'b0;
        if (n == BB) begin
            for (int i = 0; i < BB; i++) exp_q.push_back(blk[i]);
            exp_addr = exp_addr + 1'b1;
        end
        if (lat) begin
            chk("lat_cycle0", Out_Valid, 0);
            tick();
            chk("lat_cycle1", Out_Valid, 0);
            tick();
            chk("lat_cycle2", Out_Valid, 1);
        end
    endtask

    task automatic do_start(input logic [SW-1:0] sb);
        StartBlock = sb;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        exp_addr = sb;
    endtask

    task automatic do_stop();
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        set_rdy(1);
        #23;
        chk("rst_valid", Out_Valid, 0);
        chk("rst_req", SD_ReadReq, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_err", ErrorFlag, 0);
        chk("rst_underrun", Underrun, 0);
        chk("rst_addr", SD_ReadAddr, 0);
        tick();
        Reset = 1'b0;
        tick();
        chk("idle_underrun", Underrun, 0);

        // two blocks streamed with a free-running consumer
        acc0 = acc_cnt;
        do_start(16'h0010);
        chk("a_busy", Busy, 1);
        chk("a_req", SD_ReadReq, 1);
        chk("a_addr", SD_ReadAddr, 16'h0010);
        chk("a_underrun", Underrun, 1);
        send_block(BB, -1, -1, 1'b1);
        send_block(BB, -1, -1, 1'b0);
        wait_req();
        chk("a_addr3", SD_ReadAddr, exp_addr);
        do_stop();
        chk("a_stop_busy", Busy, 0);
        chk("a_stop_req", SD_ReadReq, 0);
        wait_drain();
        chk("a_count", acc_cnt - acc0, 1024);

        // consumer stalled: both banks fill, then drain without bubbles
        set_rdy(0);
        do_start(16'h0010);
        send_block(BB, -1, -1, 1'b0);
        send_block(BB, -1, -1, 1'b0);
        repeat (5) tick();
        chk("b_waitbank_req", SD_ReadReq, 0);
        chk("b_waitbank_busy", Busy, 1);
        chk("b_primed", Out_Valid, 1);
        acc0 = acc_cnt;
        bubbles = 0;
        track_end = acc_cnt + 1024;
        track = 1'b1;
        set_rdy(1);
        wait_req();
        chk("b_drain_first", (acc_cnt - acc0) >= 512, 1);
        chk("b_addr3", SD_ReadAddr, 16'h0012);
        send_block(BB, -1, -1, 1'b0);
        do_stop();
        chk("b_stop_busy", Busy, 0);
        wait_drain();
        chk("b_bubbles", bubbles, 0);

        // abort mid-block: first bank still drains, no new requests
        set_rdy(0);
        do_start(16'h0030);
        send_block(BB, -1, -1, 1'b0);
        send_block(BB, 100, -1, 1'b0);
        chk("c_errflag", ErrorFlag, 1);
        chk("c_busy", Busy, 1);
        chk("c_req", SD_ReadReq, 0);
        r0 = req_cnt;
        set_rdy(2);
        wait_drain();
        chk("c_noreq", req_cnt - r0, 0);
        set_rdy(1);
        tick();
        chk("c_err_underrun", Underrun, 0);
        chk("c_err_sticky", ErrorFlag, 1);
        do_start(16'h0040);
        chk("c_err_clear", ErrorFlag, 0);
        chk("c_restart_req", SD_ReadReq, 1);
        chk("c_restart_addr", SD_ReadAddr, 16'h0040);

        // short block is an error and never reaches the output
        send_block(BB - 1, -1, -1, 1'b0);
        chk("d_errflag", ErrorFlag, 1);
        repeat (20) tick();
        chk("d_no_output", Out_Valid, 0);
        chk("d_queue", exp_q.size(), 0);

        // Stop during a block: block completes, no further request
        set_rdy(2);
        do_start(16'h0020);
        send_block(BB, -1, 50, 1'b0);
        chk("e_busy", Busy, 0);
        r0 = req_cnt;
        wait_drain();
        chk("e_noreq", req_cnt - r0, 0);
        chk("e_req", SD_ReadReq, 0);

        // asynchronous reset in the middle of a block
        set_rdy(0);
        do_start(16'h0050);
        send_block(BB, -1, -1, 1'b0);
        wait_req();
        chk("f_addr", SD_ReadAddr, exp_addr);
        SD_ReadAck = 1'b1;
        tick();
        SD_ReadAck = 1'b0;
        send_bytes(200, -1);
        chk("f_pre_valid", Out_Valid, 1);
        #3 Reset = 1'b1;
        #1;
        chk("f_rst_valid", Out_Valid, 0);
        chk("f_rst_busy", Busy, 0);
        chk("f_rst_req", SD_ReadReq, 0);
        chk("f_rst_addr", SD_ReadAddr, 0);
        chk("f_rst_data", Out_Data, 0);
        exp_q.delete();
        set_rdy(1);
        tick();
        tick();
        Reset = 1'b0;
        repeat (10) tick();
        chk("f_post_valid", Out_Valid, 0);
        chk("f_post_busy", Busy, 0);
        chk("f_post_underrun", Underrun, 0);

        // address wraps at the top of the address space
        do_start(16'hFFFF);
        chk("g_addr0", SD_ReadAddr, 16'hFFFF);
        send_block(BB, -1, -1, 1'b0);
        wait_req();
        chk("g_wrap_addr", SD_ReadAddr, 16'h0000);
        do_stop();
        chk("g_busy", Busy, 0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
